// File: rtl/icache_pkg.sv
// ============================================================================
// icache_pkg
//   Shared definitions for the instruction cache:
//     - default geometry (address width, line count, words per line)
//     - derived field widths for the default geometry
//     - FSM state encoding
//     - address field extraction and saturating increment helpers
// ============================================================================
package icache_pkg;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_NUM_LINES      = 64;
    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int WORD_W             = 16;

    // Field widths for the default geometry: addr = {tag, index, offset, byte}
    localparam int DEF_OFF_W = $clog2(DEF_WORDS_PER_LINE);
    localparam int DEF_IDX_W = $clog2(DEF_NUM_LINES);
    localparam int DEF_TAG_W = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W - 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_e;

    // Generic bit-field extract; callers truncate the result to the field width.
    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int          lsb,
                                               input int          width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// ============================================================================
// icache_data_array
//   Instruction storage: NUM_LINES lines of WORDS_PER_LINE words each.
//   One asynchronous read port (the hit path returns data in the same cycle)
//   and one synchronous write port used by line fills. Contents are not reset.
//
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_line  in   line index to write
//   wr_word  in   word within the line to write
//   wr_data  in   word to store
//   rd_line  in   line index to read
//   rd_word  in   word within the line to read
//   rd_data  out  word read (combinational)
// ============================================================================
module icache_data_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    localparam int IDX_W         = $clog2(NUM_LINES),
    localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_line,
    input  logic [OFF_W-1:0]  wr_word,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_line,
    input  logic [OFF_W-1:0]  rd_word,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] line_rd [NUM_LINES];

    // One small word array per line; the read is a word mux inside each line
    // followed by a line mux.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic [WORD_W-1:0] words [WORDS_PER_LINE];

            always_ff @(posedge clk) begin
                if (wr_en && (wr_line == IDX_W'(gi))) begin
                    words[wr_word] <= wr_data;
                end
            end

            assign line_rd[gi] = words[rd_word];
        end
    endgenerate

    assign rd_data = line_rd[rd_line];

endmodule

// File: rtl/icache_fetch.sv
// ============================================================================
// icache_fetch
//   Direct-mapped, read-only instruction cache between the IF stage and a
//   pipelined instruction memory with fixed return latency.
//   A hit returns the instruction combinationally with no stall. A miss holds
//   if_stall while the whole line is refilled; one request is issued per cycle
//   and returns are written in order. if_inv clears every valid bit.
//
//   clk        in   clock
//   rst_n      in   asynchronous reset, active low
//   if_req     in   fetch request this cycle
//   if_addr    in   fetch byte address
//   if_inst    out  instruction, valid when if_req & ~if_stall
//   if_stall   out  miss in progress
//   if_inv     in   invalidate all lines
//   mem_req    out  memory read request (one word per cycle)
//   mem_addr   out  word-aligned request address
//   mem_valid  in   returned word valid (in request order)
//   mem_data   in   returned word
//   miss_cnt   out  saturating miss counter
// ============================================================================
module icache_fetch
    import icache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_inst,
    output logic              if_stall,
    input  logic              if_inv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [WORD_W-1:0] mem_data,
    output logic [15:0]       miss_cnt
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int OFF_LSB = 1;
    localparam int IDX_LSB = OFF_LSB + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    // Issue counter needs one extra bit so it can reach WORDS_PER_LINE.
    localparam int CNT_W   = OFF_W + 1;

    // ------------------------------------------------------------------
    // Request address decomposition
    // ------------------------------------------------------------------
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    assign req_off = OFF_W'(addr_field(32'(if_addr), OFF_LSB, OFF_W));
    assign req_idx = IDX_W'(addr_field(32'(if_addr), IDX_LSB, IDX_W));
    assign req_tag = TAG_W'(addr_field(32'(if_addr), TAG_LSB, TAG_W));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    icache_state_e     state_reg;
    logic [IDX_W-1:0]  fill_idx_reg;
    logic [TAG_W-1:0]  fill_tag_reg;
    logic [CNT_W-1:0]  issue_cnt_reg;   // requests issued so far in this fill
    logic [OFF_W-1:0]  ret_cnt_reg;     // next word slot to be written
    logic              mem_req_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [15:0]       miss_cnt_reg;
    logic [15:0]       miss_cnt_next;

    logic [NUM_LINES-1:0] valid_reg;
    logic [TAG_W-1:0]     tag_reg [NUM_LINES];

    // ------------------------------------------------------------------
    // Hit / miss / fill decode
    // ------------------------------------------------------------------
    logic hit;
    logic miss;
    logic fill_wr;
    logic fill_last;

    assign hit       = if_req && valid_reg[req_idx] && (tag_reg[req_idx] == req_tag);
    assign miss      = (state_reg == IDLE) && if_req && !hit;
    assign fill_wr   = (state_reg == FILL) && mem_valid;
    assign fill_last = fill_wr && (ret_cnt_reg == OFF_W'(WORDS_PER_LINE - 1));

    assign if_stall      = (state_reg == FILL) || miss;
    assign miss_cnt_next = sat_inc16(miss_cnt_reg);

    // ------------------------------------------------------------------
    // Fill FSM, request generator and miss counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            fill_idx_reg  <= '0;
            fill_tag_reg  <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss) begin
                        // The first request goes out in the first FILL cycle,
                        // so it is already counted as issued here.
                        state_reg     <= FILL;
                        fill_idx_reg  <= req_idx;
                        fill_tag_reg  <= req_tag;
                        issue_cnt_reg <= CNT_W'(1);
                        ret_cnt_reg   <= '0;
                        mem_req_reg   <= 1'b1;
                        mem_addr_reg  <= {req_tag, req_idx, {(OFF_W + 1){1'b0}}};
                        miss_cnt_reg  <= miss_cnt_next;
                    end
                end
                FILL: begin
                    if (mem_req_reg) begin
                        if (issue_cnt_reg == CNT_W'(WORDS_PER_LINE)) begin
                            mem_req_reg <= 1'b0;
                        end else begin
                            mem_addr_reg  <= mem_addr_reg + ADDR_W'(2);
                            issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                        end
                    end
                    if (fill_wr) begin
                        ret_cnt_reg <= ret_cnt_reg + OFF_W'(1);
                        if (fill_last) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Valid bits: invalidate has priority over the completing fill.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (if_inv) begin
            valid_reg <= '0;
        end else if (fill_last) begin
            valid_reg[fill_idx_reg] <= 1'b1;
        end
    end

    // Tags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (fill_last) begin
            tag_reg[fill_idx_reg] <= fill_tag_reg;
        end
    end

    // ------------------------------------------------------------------
    // Data storage
    // ------------------------------------------------------------------
    icache_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_data (
        .clk     (clk),
        .wr_en   (fill_wr),
        .wr_line (fill_idx_reg),
        .wr_word (ret_cnt_reg),
        .wr_data (mem_data),
        .rd_line (req_idx),
        .rd_word (req_off),
        .rd_data (if_inst)
    );

    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign miss_cnt = miss_cnt_reg;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed testbench for icache_fetch with a fixed-latency (L=4) memory model.
module tb_icache_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_inst;
    logic        if_stall;
    logic        if_inv;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic [15:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_inst   (if_inst),
        .if_stall  (if_stall),
        .if_inv    (if_inv),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .miss_cnt  (miss_cnt)
    );

    // ---------------- memory model: return L=4 cycles after request ----
    function automatic logic [15:0] word_of(input logic [15:0] a);
        return a ^ 16'hBEEF;
    endfunction

    logic [3:0]  pv = 4'b0;
    logic [15:0] pa [4];

    always @(posedge clk) begin
        pv <= {pv[2:0], mem_req};
        pa[0] <= mem_addr;
        for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
    end

    assign mem_valid = pv[3];
    assign mem_data  = word_of(pa[3]);

    // ---------------- fetch driver (records observations only) ---------
    int          f_stalls;
    logic [15:0] f_inst;
    logic [15:0] req_q[$];
    int          reqc_q[$];

    task automatic do_fetch(input logic [15:0] addr, input int chg_at,
                            input logic [15:0] chg_addr, input int inv_at);
        bit done = 0;
        f_stalls = 0;
        f_inst   = 'x;
        req_q.delete();
        reqc_q.delete();
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c == chg_at) if_addr = chg_addr;
            if_inv = (c == inv_at);
            #1;
            if (mem_req) begin
                req_q.push_back(mem_addr);
                reqc_q.push_back(c);
            end
            if (!if_stall) begin
                f_inst = if_inst;
                done   = 1;
            end else begin
                f_stalls++;
            end
            @(negedge clk);
        end
        if_req = 1'b0;
        if_inv = 1'b0;
        if (!done) f_stalls = -1;
        $display("fetch addr=%h stalls=%0d reqs=%0d inst=%h miss_cnt=%0d",
                 addr, f_stalls, req_q.size(), f_inst, miss_cnt);
    endtask

    // True when req_q[first..first+n-1] are base, base+2, ... on consecutive cycles.
    function automatic bit run_ok(input int first, input int n, input logic [15:0] base);
        if (req_q.size() < first + n) return 0;
        for (int i = 0; i < n; i++) begin
            if (req_q[first+i] !== base + 16'(2*i)) return 0;
            if (reqc_q[first+i] != reqc_q[first] + i) return 0;
        end
        return 1;
    endfunction

    // ---------------- scenarios ----------------------------------------
    task automatic test_reset;
        rst_n = 1'b0; if_req = 1'b0; if_addr = 16'h0; if_inv = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0000", mem_addr); end
        checks++; if (miss_cnt !== 16'h0) begin failures++; $display("FAIL reset_miss_cnt got=%h want=0000", miss_cnt); end
        checks++; if (if_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%b want=0", if_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0000;
        #1;
        checks++; if (if_stall !== 1'b1) begin failures++; $display("FAIL cold_stall got=%b want=1", if_stall); end
        #1 if_req = 1'b0;
    endtask

    task automatic test_cold_miss;
        do_fetch(16'h0000, -1, 16'h0, -1);
        checks++; if (f_stalls !== 13) begin failures++; $display("FAIL cold_stalls got=%0d want=13", f_stalls); end
        checks++; if (req_q.size() !== 8) begin failures++; $display("FAIL cold_req_count got=%0d want=8", req_q.size()); end
        checks++; if (run_ok(0, 8, 16'h0000) !== 1'b1) begin failures++; $display("FAIL cold_req_seq got=0 want=1"); end
        checks++; if (reqc_q.size() > 0 && reqc_q[0] !== 1) begin failures++; $display("FAIL cold_first_req_cycle got=%0d want=1", reqc_q[0]); end
        checks++; if (f_inst !== word_of(16'h0000)) begin failures++; $display("FAIL cold_inst got=%h want=%h", f_inst, word_of(16'h0000)); end
        checks++; if (miss_cnt !== 16'd1) begin failures++; $display("FAIL cold_miss_cnt got=%0d want=1", miss_cnt); end
        do_fetch(16'h000E, -1, 16'h0, -1);
        checks++; if (f_stalls !== 0) begin failures++; $display("FAIL hit_stalls got=%0d want=0", f_stalls); end
        checks++; if (f_inst !== word_of(16'h000E)) begin failures++; $display("FAIL hit_inst got=%h want=%h", f_inst, word_of(16'h000E)); end
        checks++; if (req_q.size() !== 0) begin failures++; $display("FAIL hit_req_count got=%0d want=0", req_q.size()); end
    endtask

    task automatic test_conflict;
        do_fetch(16'h0400, -1, 16'h0, -1);
        checks++; if (f_stalls !== 13) begin failures++; $display("FAIL conf_stalls got=%0d want=13", f_stalls); end
        checks++; if (run_ok(0, 8, 16'h0400) !== 1'b1) begin failures++; $display("FAIL conf_req_seq got=0 want=1"); end
        checks++; if (f_inst !== word_of(16'h0400)) begin failures++; $display("FAIL conf_inst got=%h want=%h", f_inst, word_of(16'h0400)); end
        do_fetch(16'h040A, -1, 16'h0, -1);
        checks++; if (f_stalls !== 0 || f_inst !== word_of(16'h040A)) begin failures++; $display("FAIL conf_hit got=%0d/%h want=0/%h", f_stalls, f_inst, word_of(16'h040A)); end
        do_fetch(16'h0000, -1, 16'h0, -1);
        checks++; if (f_stalls !== 13) begin failures++; $display("FAIL conf_back_stalls got=%0d want=13", f_stalls); end
        checks++; if (miss_cnt !== 16'd3) begin failures++; $display("FAIL conf_miss_cnt got=%0d want=3", miss_cnt); end
    endtask

    task automatic test_addr_change;
        do_fetch(16'h0400, 5, 16'h0020, -1);
        checks++; if (f_stalls !== 26) begin failures++; $display("FAIL chg_stalls got=%0d want=26", f_stalls); end
        checks++; if (req_q.size() !== 16) begin failures++; $display("FAIL chg_req_count got=%0d want=16", req_q.size()); end
        checks++; if (run_ok(0, 8, 16'h0400) !== 1'b1) begin failures++; $display("FAIL chg_first_fill got=0 want=1"); end
        checks++; if (run_ok(8, 8, 16'h0020) !== 1'b1) begin failures++; $display("FAIL chg_second_fill got=0 want=1"); end
        checks++; if (f_inst !== word_of(16'h0020)) begin failures++; $display("FAIL chg_inst got=%h want=%h", f_inst, word_of(16'h0020)); end
        do_fetch(16'h0406, -1, 16'h0, -1);
        checks++; if (f_stalls !== 0 || f_inst !== word_of(16'h0406)) begin failures++; $display("FAIL chg_line0_hit got=%0d/%h want=0/%h", f_stalls, f_inst, word_of(16'h0406)); end
        checks++; if (miss_cnt !== 16'd5) begin failures++; $display("FAIL chg_miss_cnt got=%0d want=5", miss_cnt); end
    endtask

    task automatic test_invalidate;
        @(negedge clk); if_inv = 1'b1;
        @(negedge clk); if_inv = 1'b0;
        do_fetch(16'h0400, -1, 16'h0, -1);
        checks++; if (f_stalls !== 13) begin failures++; $display("FAIL inv_refetch_stalls got=%0d want=13", f_stalls); end
        // invalidate in the cycle of the last returned word (cycle 12)
        do_fetch(16'h0000, -1, 16'h0, 12);
        checks++; if (f_stalls !== 26) begin failures++; $display("FAIL inv_last_stalls got=%0d want=26", f_stalls); end
        checks++; if (run_ok(0, 8, 16'h0000) !== 1'b1 || run_ok(8, 8, 16'h0000) !== 1'b1) begin failures++; $display("FAIL inv_last_reqs got=0 want=1"); end
        checks++; if (f_inst !== word_of(16'h0000)) begin failures++; $display("FAIL inv_last_inst got=%h want=%h", f_inst, word_of(16'h0000)); end
        checks++; if (miss_cnt !== 16'd8) begin failures++; $display("FAIL inv_miss_cnt got=%0d want=8", miss_cnt); end
        // invalidate mid-fill: the fill still validates its own line
        do_fetch(16'h0400, -1, 16'h0, 5);
        checks++; if (f_stalls !== 13) begin failures++; $display("FAIL inv_mid_stalls got=%0d want=13", f_stalls); end
        do_fetch(16'h0402, -1, 16'h0, -1);
        checks++; if (f_stalls !== 0 || f_inst !== word_of(16'h0402)) begin failures++; $display("FAIL inv_mid_hit got=%0d/%h want=0/%h", f_stalls, f_inst, word_of(16'h0402)); end
        do_fetch(16'h0020, -1, 16'h0, -1);
        checks++; if (f_stalls !== 13) begin failures++; $display("FAIL inv_other_line got=%0d want=13", f_stalls); end
    endtask

    task automatic test_reset_mid_fill;
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0000;   // line 0 holds tag 1 -> miss
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1 || miss_cnt !== 16'd11) begin failures++; $display("FAIL rst_pre got=%b/%0d want=1/11", mem_req, miss_cnt); end
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
        checks++; if (miss_cnt !== 16'd0) begin failures++; $display("FAIL rst_miss_cnt got=%0d want=0", miss_cnt); end
        checks++; if (if_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b want=0", if_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (mem_req !== 1'b0 || if_stall !== 1'b0) begin failures++; $display("FAIL rst_late_idle c=%0d got=%b/%b want=0/0", c, mem_req, if_stall); end
            @(negedge clk);
        end
        do_fetch(16'h0000, -1, 16'h0, -1);
        checks++; if (f_stalls !== 13) begin failures++; $display("FAIL rst_refetch_stalls got=%0d want=13", f_stalls); end
        checks++; if (f_inst !== word_of(16'h0000)) begin failures++; $display("FAIL rst_refetch_inst got=%h want=%h", f_inst, word_of(16'h0000)); end
        checks++; if (miss_cnt !== 16'd1) begin failures++; $display("FAIL rst_refetch_cnt got=%0d want=1", miss_cnt); end
    endtask

    task automatic test_saturate;
        logic [15:0] exp_cnt [4];
        logic [15:0] addrs [4];
        exp_cnt[0] = 16'hFFFE; exp_cnt[1] = 16'hFFFF; exp_cnt[2] = 16'hFFFF; exp_cnt[3] = 16'hFFFF;
        addrs[0] = 16'h0400; addrs[1] = 16'h0000; addrs[2] = 16'h0400; addrs[3] = 16'h0000;
        @(negedge clk);
        force dut.miss_cnt_reg = 16'hFFFD;
        #1 release dut.miss_cnt_reg;
        for (int i = 0; i < 4; i++) begin
            do_fetch(addrs[i], -1, 16'h0, -1);
            checks++; if (f_stalls !== 13) begin failures++; $display("FAIL sat_stalls[%0d] got=%0d want=13", i, f_stalls); end
            checks++; if (miss_cnt !== exp_cnt[i]) begin failures++; $display("FAIL sat_cnt[%0d] got=%h want=%h", i, miss_cnt, exp_cnt[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_addr_change();
        test_invalidate();
        test_reset_mid_fill();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
